// File: rtl/sram_arb2.sv
// Two-requester round-robin arbiter/sequencer for a single-port synchronous SRAM.
// Reads return to their owner RD_LAT cycles after acceptance; writes wait for an empty read pipeline.
module sram_arb2 #(
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_req_ready,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_req_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              lg;        // last grant: 0 = A, 1 = B
  logic [RD_LAT-1:0] pv;        // pv[0] is stage 1
  logic [RD_LAT-1:0] po;        // owner per stage: 0 = A, 1 = B
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              busy;
  logic              a_elig;
  logic              b_elig;
  logic              grant_a;
  logic              grant_b;
  logic              acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign busy   = |pv;
  assign a_elig = a_req_valid && (!a_req_we || !busy);
  assign b_elig = b_req_valid && (!b_req_we || !busy);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_elig && b_elig) begin
        grant_a = lg;
        grant_b = !lg;
      end else begin
        grant_a = a_elig;
        grant_b = b_elig;
      end
    end
  end

  assign acc       = grant_a || grant_b;
  assign sel_we    = grant_a ? a_req_we    : b_req_we;
  assign sel_addr  = grant_a ? a_req_addr  : b_req_addr;
  assign sel_wdata = grant_a ? a_req_wdata : b_req_wdata;

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  // Hold cycles keep the SRAM enabled so its read/capture stages advance.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      mem_en    = acc || busy;
      mem_we    = acc && sel_we;
      mem_addr  = acc ? sel_addr  : addr_q;
      mem_wdata = acc ? sel_wdata : wdata_q;
    end
  end

  assign a_rsp_valid = !rst && pv[RD_LAT-1] && !po[RD_LAT-1];
  assign b_rsp_valid = !rst && pv[RD_LAT-1] &&  po[RD_LAT-1];
  assign a_rsp_rdata = mem_rdata;
  assign b_rsp_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      lg      <= 1'b0;
      pv      <= '0;
      po      <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (acc) begin
        lg      <= grant_b;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      pv[0] <= acc && !sel_we;
      po[0] <= grant_b;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_arb2.sv
// Directed bench for sram_arb2 with a behavioural 2-cycle SRAM and a response scoreboard.
module tb_sram_arb2;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [AW-1:0] a_req_addr = '0;
  logic [DW-1:0] a_req_wdata = '0;
  logic          a_req_ready, a_rsp_valid;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [AW-1:0] b_req_addr = '0;
  logic [DW-1:0] b_req_wdata = '0;
  logic          b_req_ready, b_rsp_valid;
  logic [DW-1:0] b_rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  sram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 1) return 16'h1111;
    if (a == 2) return 16'h2222;
    return DW'(a * 16'h0101) ^ 16'h3C00;
  endfunction

  // Behavioural SRAM: address captured in an enabled cycle, data out two enabled edges later.
  logic          preload = 1'b1;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] s1, s2;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      s1 <= mem[mem_addr];
      s2 <= s1;
    end
  end
  assign mem_rdata = s2;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q[$];
  logic [DW-1:0] wr_ref [int];

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input int a);
    return wr_ref.exists(a) ? wr_ref[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      exp_t e;
      bit   hit;
      hit = 1'b0;
      e = '{port: 1'b0, data: '0, due: 0};
      if (q.size() > 0) begin
        e = q[0];
        chk("rsp_order", (e.due >= cyc) ? 32'd1 : 32'd0, 32'd1);
        hit = (e.due <= cyc);
      end
      chk("a_rsp_valid", a_rsp_valid, hit && !e.port);
      chk("b_rsp_valid", b_rsp_valid, hit && e.port);
      if (hit) begin
        chk(e.port ? "b_rsp_rdata" : "a_rsp_rdata",
            e.port ? b_rsp_rdata : a_rsp_rdata, e.data);
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input string tag,
                      input logic av, input logic awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                      input logic bv, input logic bwe, input logic [AW-1:0] bad_, input logic [DW-1:0] bwd,
                      input logic ea, input logic eb);
    @(negedge clk);
    a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = bad_; b_req_wdata = bwd;
    #1;
    chk({tag, "/a_ready"}, a_req_ready, ea);
    chk({tag, "/b_ready"}, b_req_ready, eb);
    if (ea || eb) begin
      logic          we;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      we = ea ? awe : bwe;
      ad = ea ? aad : bad_;
      wd = ea ? awd : bwd;
      chk({tag, "/mem_en"}, mem_en, 1'b1);
      chk({tag, "/mem_we"}, mem_we, we);
      chk({tag, "/mem_addr"}, mem_addr, ad);
      if (we) begin
        chk({tag, "/mem_wdata"}, mem_wdata, wd);
        wr_ref[int'(ad)] = wd;
      end else begin
        q.push_back('{port: eb, data: ref_rd(int'(ad)), due: cyc + LAT});
      end
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic pins(input string tag, input logic en, input logic we, input logic [AW-1:0] ad);
    chk({tag, "/mem_en"}, mem_en, en);
    chk({tag, "/mem_we"}, mem_we, we);
    chk({tag, "/mem_addr"}, mem_addr, ad);
  endtask

  initial begin
    // Reset with requests pending: nothing may be accepted.
    a_req_valid = 1'b1; b_req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst/a_ready", a_req_ready, 1'b0);
      chk("rst/b_ready", b_req_ready, 1'b0);
      pins("rst", 1'b0, 1'b0, '0);
    end
    @(negedge clk);
    rst = 1'b0; preload = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
    #1; pins("post_rst", 1'b0, 1'b0, '0);
    mon_en = 1'b1;

    // Write then read, A only.
    step("wr_a", 1, 1, 10'h012, 16'hBEEF, 0, 0, '0, '0, 1, 0);
    step("rd_a", 1, 0, 10'h012, '0,       0, 0, '0, '0, 1, 0);
    repeat (3) idle("wr_rd_idle");

    // Write guard: A write waits for B's reads to drain.
    step("wg0", 1, 1, 10'h004, 16'h5A5A, 1, 0, 10'h004, '0, 0, 1);
    step("wg1", 1, 1, 10'h004, 16'h5A5A, 1, 0, 10'h004, '0, 0, 1);
    step("wg2", 1, 1, 10'h004, 16'h5A5A, 1, 0, 10'h004, '0, 0, 1);
    step("wg3", 1, 1, 10'h004, 16'h5A5A, 0, 0, '0, '0, 0, 0);
    pins("wg3_hold", 1'b1, 1'b0, 10'h004);
    step("wg4", 1, 1, 10'h004, 16'h5A5A, 0, 0, '0, '0, 0, 0);
    pins("wg4_hold", 1'b1, 1'b0, 10'h004);
    step("wg5", 1, 1, 10'h004, 16'h5A5A, 0, 0, '0, '0, 1, 0);
    step("wg_rd", 1, 0, 10'h004, '0, 0, 0, '0, '0, 1, 0);
    repeat (3) idle("wg_idle");

    // Back-to-back B reads; SRAM stays enabled through the last capture.
    step("b2b0", 0, 0, '0, '0, 1, 0, 10'h010, '0, 0, 1);
    step("b2b1", 0, 0, '0, '0, 1, 0, 10'h011, '0, 0, 1);
    step("b2b2", 0, 0, '0, '0, 1, 0, 10'h012, '0, 0, 1);
    idle("b2b_h1"); pins("b2b_h1", 1'b1, 1'b0, 10'h012);
    idle("b2b_h2"); pins("b2b_h2", 1'b1, 1'b0, 10'h012);
    idle("b2b_end"); pins("b2b_end", 1'b0, 1'b0, 10'h012);

    // Reset mid-read: the accepted read is dropped.
    step("rr_rd", 1, 0, 10'h001, '0, 0, 0, '0, '0, 1, 0);
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rr_rst/a_ready", a_req_ready, 1'b0);
    pins("rr_rst", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0; a_req_valid = 1'b0;
    #1;
    chk("rr_after/a_rsp_valid", a_rsp_valid, 1'b0);
    pins("rr_after", 1'b0, 1'b0, '0);

    // Contention from reset: B first, then alternate.
    for (int i = 0; i < 6; i++) begin
      step("cont", 1, 0, 10'h001, '0, 1, 0, 10'h002, '0, (i % 2) == 1, (i % 2) == 0);
    end
    repeat (4) idle("cont_idle");
    chk("scoreboard_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arb2.md
Name: sram_arb2

Overview:
- Two-requester arbiter and sequencer for one single-port synchronous SRAM in the 16-bit RISC core.
- Requester A is instruction fetch and requester B is load/store.
- Accepts at most one access per cycle, drives the SRAM enable/write/address/data pins, and returns read data to the owning requester a fixed RD_LAT cycles after acceptance.
- Round-robin arbitration with a write-hazard guard.

Parameters:
- ADDR_W, 10, SRAM word-address width.
- DATA_W, 16, data width.
- RD_LAT, 2, cycles from read acceptance (SRAM pins driven) to SRAM read data valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- a_req_valid  in  1  requester A access request
- a_req_we  in  1  1 = write, 0 = read
- a_req_addr  in  ADDR_W  word address
- a_req_wdata  in  DATA_W  write data
- a_req_ready  out  1  A accepted this cycle
- a_rsp_valid  out  1  A read data valid (1-cycle pulse)
- a_rsp_rdata  out  DATA_W  A read data
- b_req_valid / b_req_we / b_req_addr / b_req_wdata / b_req_ready / b_rsp_valid / b_rsp_rdata  same as A, for requester B
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data

Behaviour:
- Handshake: a request transfers when req_valid && req_ready in the same cycle. req_ready is combinational from the valids and internal state. The requester holds valid/we/addr/wdata stable until accepted.
- Accepted access drives the SRAM pins combinationally in the acceptance cycle: mem_en=1, mem_we=req_we, mem_addr=req_addr, mem_wdata=req_wdata.
- Arbitration:
  - 1-bit last-grant pointer lg, reset 0 (A), updated to the granted requester on every acceptance.
  - Both eligible: grant the requester that is not lg.
  - Only one eligible: grant it; no idle slots.
- Write guard:
  - A write is eligible only when no read is in flight (read pipeline empty). This keeps mem_we low during every read capture cycle.
  - Reads are always eligible and may issue back-to-back, one per cycle.
  - A write that loses eligibility stays pending; the other requester's reads keep proceeding. Write starvation is acceptable and bounded by read traffic from the other port.
- Read pipeline:
  - RD_LAT-deep shift register of {valid, owner}, shifted every cycle.
  - A read accepted in cycle N makes owner_rsp_valid=1 in cycle N+RD_LAT, with rsp_rdata = mem_rdata in that cycle.
  - The non-owner rsp_valid stays 0.
  - rsp_rdata for both ports is mem_rdata, wired unconditionally; meaningful only with rsp_valid.
- mem_en:
  - 1 in any acceptance cycle.
  - Also 1 in every cycle in which any read pipeline stage 1..RD_LAT is valid, so the SRAM read/capture stages advance.
  - In those hold cycles with no acceptance: mem_we=0 and mem_addr/mem_wdata hold their last driven values (registered shadow).
- Idle: mem_en=0, mem_we=0, mem_addr/mem_wdata hold last values.
- Writes produce no response.
- Reset (synchronous, any time including mid-read):
  - Clear the pipeline and set lg=0.
  - Outputs in and after the reset cycle: a/b_req_ready=0, a/b_rsp_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - In-flight reads are dropped and never respond.
- Simultaneous events:
  - A response and a new acceptance in the same cycle are independent.
  - The same requester may have up to RD_LAT reads outstanding; responses return in acceptance order.

Test Plan:
- Write then read, A only: A writes 0xBEEF @0x012 (accepted cycle 0). A reads @0x012 at cycle 1 → a_rsp_valid=1, a_rsp_rdata=0xBEEF at cycle 3 (RD_LAT=2); b_rsp_valid=0 throughout.
- Contention: A and B both request reads continuously from reset.
  - Expected grants: B, A, B, A… (lg starts at A).
  - With mem[0x001]=0x1111 (A addr) and mem[0x002]=0x2222 (B addr), responses alternate b=0x2222, a=0x1111 starting cycle 2.
- Write guard: B streams reads @0x004 for 3 cycles while A requests a write of 0x5A5A @0x004 from cycle 0.
  - A's write is accepted only when the pipeline is empty (cycle 5).
  - B's three responses carry the old value; a subsequent read returns 0x5A5A.
- Back-to-back reads: B reads 0x010, 0x011, 0x012 on consecutive cycles → three consecutive b_rsp_valid pulses, in order, with the matching data; mem_en stays high through the last capture cycle, then drops.
- Reset mid-read: A read accepted at cycle 0, rst=1 at cycle 1 → no a_rsp_valid at cycle 2; mem_en=0, mem_addr=0 during and after reset; first post-reset contention grants B.
